// File: rtl/gate_response_checker.sv
// Observes a 2-input gate (a, b -> o), waits for settled inputs, checks o against TRUTH_TABLE.
// Accumulates saturating pass/fail counts, per-combination coverage and a sticky first-error index.
module gate_response_checker #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0110,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             a,
  input  logic             b,
  input  logic             o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       coverage,
  output logic             err,
  output logic [1:0]       first_fail_idx
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, WAIT_CHG, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       SETTLE_T = 8'(SETTLE_CYCLES);

  state_t           state, state_nxt;
  logic [7:0]       timer, timer_nxt;
  logic [1:0]       cap, cap_nxt;
  logic [CNT_W-1:0] pass_nxt, fail_nxt;
  logic [3:0]       coverage_nxt;
  logic             err_nxt;
  logic [1:0]       ffi_nxt;
  logic [1:0]       ab;

  assign ab = {a, b};

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    cap_nxt      = cap;
    pass_nxt     = pass_cnt;
    fail_nxt     = fail_cnt;
    coverage_nxt = coverage;
    err_nxt      = err;
    ffi_nxt      = first_fail_idx;
    if (start) begin
      pass_nxt     = '0;
      fail_nxt     = '0;
      coverage_nxt = '0;
      err_nxt      = 1'b0;
      ffi_nxt      = 2'b00;
      cap_nxt      = ab;
      timer_nxt    = 8'd1;
      state_nxt    = SETTLE;
    end else begin
      case (state)
        SETTLE: begin
          if (stop) begin
            state_nxt = DONE;
          end else if (ab != cap) begin
            cap_nxt   = ab;
            timer_nxt = 8'd1;
          end else if (timer == SETTLE_T) begin
            state_nxt = SAMPLE;
          end else begin
            timer_nxt = timer + 8'd1;
          end
        end
        SAMPLE: begin
          if (stop) begin
            state_nxt = DONE;
          end else if (ab != cap) begin
            // inputs moved during the sample cycle: discard and resettle
            cap_nxt   = ab;
            timer_nxt = 8'd1;
            state_nxt = SETTLE;
          end else begin
            if (o == TRUTH_TABLE[cap]) begin
              if (pass_cnt != CNT_MAX) pass_nxt = pass_cnt + 1'b1;
            end else begin
              if (fail_cnt != CNT_MAX) fail_nxt = fail_cnt + 1'b1;
              if (!err) begin
                err_nxt = 1'b1;
                ffi_nxt = cap;
              end
            end
            coverage_nxt[cap] = 1'b1;
            state_nxt         = WAIT_CHG;
          end
        end
        WAIT_CHG: begin
          if (stop) begin
            state_nxt = DONE;
          end else if (ab != cap) begin
            cap_nxt   = ab;
            timer_nxt = 8'd1;
            state_nxt = SETTLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      timer          <= 8'd0;
      cap            <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      coverage       <= 4'b0000;
      err            <= 1'b0;
      first_fail_idx <= 2'b00;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      cap            <= cap_nxt;
      busy           <= (state_nxt == SETTLE) || (state_nxt == SAMPLE) || (state_nxt == WAIT_CHG);
      done           <= (state_nxt == DONE);
      pass_cnt       <= pass_nxt;
      fail_cnt       <= fail_nxt;
      coverage       <= coverage_nxt;
      err            <= err_nxt;
      first_fail_idx <= ffi_nxt;
    end
  end

endmodule
